dff_piso_tx: RTL

DFF_PISO_TX -- requirements
Module: dff_piso_tx

---
 rtl/dff_piso_tx.sv | 68 ++++++
 1 files changed

// File: rtl/dff_piso_tx.sv
// dff_piso_tx: parallel-in serial-out transmitter with ready/valid load and shift enable
// Ports:
//   CLK      - clock, rising edge
//   RST      - asynchronous active-low reset
//   EN       - shift enable; the serial bit advances only on edges with EN=1
//   LD_VALID - parallel word offered
//   LD_DATA  - parallel word (WIDTH bits)
//   LD_READY - idle and able to accept a word
//   SDO      - serial data out, 0 when no frame bit is present
//   SVALID   - SDO carries a frame bit
//   DONE     - one-cycle pulse after the last bit has been shifted out
module dff_piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LD_VALID,
  input  logic [WIDTH-1:0] LD_DATA,
  output logic             LD_READY,
  output logic             SDO,
  output logic             SVALID,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    last    = cnt_q == CW'(WIDTH - 1);
    if (state_q == IDLE && LD_VALID) begin
      state_d = SHIFT;
      sr_d    = LD_DATA;
      cnt_d   = '0;
    end else if (state_q == SHIFT && EN) begin
      // The final bit leaves the register untouched; SDO is gated off in IDLE.
      state_d = last ? IDLE : SHIFT;
      done_d  = last;
      sr_d    = last ? sr_q : (MSB_FIRST != 0 ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]});
      cnt_d   = last ? cnt_q : cnt_q + CW'(1);
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign LD_READY = state_q == IDLE;
  assign SVALID   = state_q == SHIFT;
  assign SDO      = SVALID & (MSB_FIRST != 0 ? sr_q[WIDTH-1] : sr_q[0]);
  assign DONE     = done_q;
endmodule
